hero_write_rx: RTL and testbench

Receive end of the hero write bus. Samples `hero_write_t` beats (IDLE/VALID/DONE cycle types), buffers them in a small FIFO, and presents framed beats to a downstream consumer over a valid/ready handshake. The hero bus has no backpressure, so the block enforces framing itself:
- truncates over-length or overflowing transactions,
- drops beats it cannot store,
- reports errors through sticky status.

---
 rtl/hero_write_rx_pkg.sv | 50 +++++
 rtl/hero_rx_fifo.sv | 62 ++++++
 rtl/hero_write_rx.sv | 165 ++++++++++++++++
 tb/tb_hero_write_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hero_write_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hero_write_rx_pkg                                                    |
// | Shared types and sizing for the hero write bus and its receiver.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hero_write_rx_pkg;

  function automatic int hero_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam logic [1:0] HERO_CYC_IDLE    = 2'd0;
  localparam logic [1:0] HERO_CYC_VALID   = 2'd1;
  localparam logic [1:0] HERO_CYC_DONE    = 2'd2;
  localparam logic [1:0] HERO_CYC_ILLEGAL = 2'd3;

  typedef logic [6:0] sub_def_t;

  typedef struct packed {
    logic [1:0]  cycle_type;
    logic [35:0] wdat;
    sub_def_t    another_type_reference;
    logic        clk_en;
  } hero_write_t;

  typedef struct packed {
    logic [35:0] wdat;
    sub_def_t    sub;
    logic        last;
    logic        trunc;
  } hero_rx_beat_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_PKT  = 2'd1,
    RX_DROP = 2'd2
  } HERO_RX_STATE_E;

  localparam int HERO_RX_DEPTH     = 8;
  localparam int HERO_RX_MAX_BEATS = 16;
  localparam int HERO_RX_CNT_W     = hero_clog2(HERO_RX_DEPTH) + 1;
  localparam int HERO_RX_BCNT_W    = hero_clog2(HERO_RX_MAX_BEATS + 1);
  localparam int HERO_RX_BEAT_W    = $bits(hero_rx_beat_t);

endpackage
`default_nettype wire

// File: rtl/hero_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hero_rx_fifo                                                         |
// | Generic synchronous FIFO with occupancy count and no bypass path.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hero_rx_fifo
  import hero_write_rx_pkg::*;
#(
  parameter int WIDTH = 45,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [hero_clog2(DEPTH):0] cnt,
  output logic                       empty
);

  localparam int AW = hero_clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign w_do_push = push & ~w_full;
  assign w_do_pop  = pop & ~empty;
  assign cnt       = r_cnt;
  // Head reads as zero when empty so the output is defined straight out of reset.
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hero_write_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hero_write_rx                                                        |
// | Hero write bus receiver: framing FSM, beat FIFO and sticky status.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hero_write_rx
  import hero_write_rx_pkg::*;
#(
  parameter int DEPTH      = HERO_RX_DEPTH,
  parameter int MAX_BEATS  = HERO_RX_MAX_BEATS,
  parameter int DROP_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  hero_write_t                hero_wr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output hero_rx_beat_t              out_beat_o,
  input  logic                       status_clr_i,
  output logic                       illegal_o,
  output logic                       trunc_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  output logic [hero_clog2(DEPTH):0] fifo_cnt_o
);

  localparam int CNT_W  = hero_clog2(DEPTH) + 1;
  localparam int BCNT_W = hero_clog2(MAX_BEATS + 1);

  HERO_RX_STATE_E        r_state;
  HERO_RX_STATE_E        w_state_nxt;
  logic [BCNT_W-1:0]     r_bcnt;
  logic [BCNT_W-1:0]     w_bcnt_nxt;
  logic [BCNT_W-1:0]     w_bcnt_inc;
  logic [CNT_W-1:0]      w_fifo_cnt;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  r_illegal;
  logic                  r_trunc;
  logic                  w_is_valid;
  logic                  w_is_done;
  logic                  w_is_beat;
  logic                  w_is_illegal;
  logic                  w_room;
  logic                  w_one_left;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_set_trunc;
  logic                  w_last;
  logic                  w_trunc;
  logic                  w_empty;
  hero_rx_beat_t         w_push_beat;

  assign w_is_valid   = hero_wr_i.clk_en & (hero_wr_i.cycle_type == HERO_CYC_VALID);
  assign w_is_done    = hero_wr_i.clk_en & (hero_wr_i.cycle_type == HERO_CYC_DONE);
  assign w_is_beat    = w_is_valid | w_is_done;
  assign w_is_illegal = hero_wr_i.clk_en & (hero_wr_i.cycle_type == HERO_CYC_ILLEGAL);

  // Room is judged on the registered count; a same-cycle pop is not credited.
  assign w_room     = (w_fifo_cnt < CNT_W'(DEPTH));
  assign w_one_left = (w_fifo_cnt == CNT_W'(DEPTH - 1));
  assign w_bcnt_inc = r_bcnt + BCNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_set_trunc = 1'b0;
    w_last      = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      RX_IDLE, RX_PKT: begin
        if (w_is_beat) begin
          if (w_room) begin
            w_push  = 1'b1;
            w_last  = w_is_done | (w_bcnt_inc == BCNT_W'(MAX_BEATS)) | w_one_left;
            w_trunc = w_last & w_is_valid;
            if (w_is_done) begin
              w_state_nxt = RX_IDLE;
              w_bcnt_nxt  = '0;
            end else if (w_trunc) begin
              w_state_nxt = RX_DROP;
              w_bcnt_nxt  = '0;
              w_set_trunc = 1'b1;
            end else begin
              w_state_nxt = RX_PKT;
              w_bcnt_nxt  = w_bcnt_inc;
            end
          end else begin
            w_drop      = 1'b1;
            w_state_nxt = w_is_done ? RX_IDLE : RX_DROP;
            w_bcnt_nxt  = '0;
          end
        end
      end
      RX_DROP: begin
        if (w_is_beat) begin
          w_drop = 1'b1;
          if (w_is_done) w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
        w_bcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal  <= 1'b0;
      r_trunc    <= 1'b0;
      r_drop_cnt <= '0;
    end else if (status_clr_i) begin
      r_illegal  <= 1'b0;
      r_trunc    <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_is_illegal) r_illegal <= 1'b1;
      if (w_set_trunc)  r_trunc   <= 1'b1;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign w_push_beat.wdat  = hero_wr_i.wdat;
  assign w_push_beat.sub   = hero_wr_i.another_type_reference;
  assign w_push_beat.last  = w_last;
  assign w_push_beat.trunc = w_trunc;

  hero_rx_fifo #(
    .WIDTH (HERO_RX_BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_beat),
    .pop       (out_valid_o & out_ready_i),
    .head      (out_beat_o),
    .cnt       (w_fifo_cnt),
    .empty     (w_empty)
  );

  assign out_valid_o = ~w_empty;
  assign fifo_cnt_o  = w_fifo_cnt;
  assign illegal_o   = r_illegal;
  assign trunc_o     = r_trunc;
  assign drop_cnt_o  = r_drop_cnt;

  // One_left always truncates, so a mid-packet beat must never meet a full FIFO.
  a_no_full_in_pkt : assert property (@(posedge clk) disable iff (!rst_n)
    !((r_state == RX_PKT) && w_is_beat && !w_room));

endmodule
`default_nettype wire

// File: tb/tb_hero_write_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hero_write_rx                                                     |
// | Directed plus random stimulus against a queue-based reference model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hero_write_rx;
  import hero_write_rx_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXB  = 16;
  localparam int DCW   = 4;
  localparam int DMAX  = (1 << DCW) - 1;

  logic          clk;
  logic          rst_n;
  hero_write_t   hero_wr;
  logic          out_valid;
  logic          out_ready;
  hero_rx_beat_t out_beat;
  logic          status_clr;
  logic          illegal;
  logic          trunc;
  logic [DCW-1:0] drop_cnt;
  logic [3:0]    fifo_cnt;

  hero_write_rx #(.DEPTH(DEPTH), .MAX_BEATS(MAXB), .DROP_CNT_W(DCW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hero_wr_i    (hero_wr),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_beat_o   (out_beat),
    .status_clr_i (status_clr),
    .illegal_o    (illegal),
    .trunc_o      (trunc),
    .drop_cnt_o   (drop_cnt),
    .fifo_cnt_o   (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of expected beats; a transaction is
  // either being accepted (with its beat count) or having its tail discarded.
  logic [44:0] m_q[$];
  bit          m_dropping;
  int          m_count;
  bit          m_illegal;
  bit          m_trunc;
  int          m_drop;

  function automatic void model_reset();
    m_q.delete();
    m_dropping = 0;
    m_count    = 0;
    m_illegal  = 0;
    m_trunc    = 0;
    m_drop     = 0;
  endfunction

  function automatic void model_step(input hero_write_t b, input logic rdy, input logic clr);
    int  occ;
    bit  is_v, is_d, lst, trn, set_ill, set_trn, dropped;
    occ     = m_q.size();
    is_v    = b.clk_en && b.cycle_type == 2'd1;
    is_d    = b.clk_en && b.cycle_type == 2'd2;
    set_ill = b.clk_en && b.cycle_type == 2'd3;
    set_trn = 0;
    dropped = 0;
    if (occ > 0 && rdy) void'(m_q.pop_front());
    if (is_v || is_d) begin
      if (m_dropping) begin
        dropped = 1;
        if (is_d) m_dropping = 0;
      end else if (occ < DEPTH) begin
        lst = is_d || (m_count + 1 == MAXB) || (occ == DEPTH - 1);
        trn = lst && is_v;
        m_q.push_back({b.wdat, b.another_type_reference, lst, trn});
        if (is_d) m_count = 0;
        else if (trn) begin m_count = 0; m_dropping = 1; set_trn = 1; end
        else m_count++;
      end else begin
        dropped = 1;
        m_count = 0;
        if (is_v) m_dropping = 1;
      end
    end
    if (clr) begin
      m_illegal = 0; m_trunc = 0; m_drop = 0;
    end else begin
      if (set_ill) m_illegal = 1;
      if (set_trn) m_trunc = 1;
      if (dropped && m_drop < DMAX) m_drop++;
    end
  endfunction

  function automatic hero_write_t mk(input logic [1:0] ct, input logic [35:0] d,
                                     input logic [6:0] s, input logic en);
    hero_write_t b;
    b.cycle_type = ct;
    b.wdat = d;
    b.another_type_reference = s;
    b.clk_en = en;
    return b;
  endfunction

  task automatic compare_all();
    check_eq("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) check_eq("out_beat", out_beat, m_q[0]);
    check_eq("fifo_cnt", fifo_cnt, m_q.size());
    check_eq("drop_cnt", drop_cnt, m_drop);
    check_eq("illegal", illegal, m_illegal);
    check_eq("trunc_o", trunc, m_trunc);
  endtask

  task automatic cyc(input hero_write_t b, input logic rdy, input logic clr);
    hero_wr    = b;
    out_ready  = rdy;
    status_clr = clr;
    @(posedge clk);
    model_step(b, rdy, clr);
    #1;
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_beat"},  out_beat, 0);
    check_eq({tag, "_fcnt"},  fifo_cnt, 0);
    check_eq({tag, "_drop"},  drop_cnt, 0);
    check_eq({tag, "_ill"},   illegal, 0);
    check_eq({tag, "_trunc"}, trunc, 0);
  endtask

  hero_write_t IDL;

  initial begin
    IDL        = mk(2'd0, 36'd0, 7'd0, 1'b1);
    rst_n      = 1'b0;
    hero_wr    = IDL;
    out_ready  = 1'b0;
    status_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic framing
    cyc(mk(2'd1, 36'h1, 7'h11, 1), 1, 0);
    cyc(mk(2'd1, 36'h2, 7'h12, 1), 1, 0);
    cyc(mk(2'd2, 36'h3, 7'h13, 1), 1, 0);
    check_eq("basic_last", out_beat.last, 1);
    cyc(IDL, 1, 0);

    // Idle and gated cycles
    cyc(mk(2'd1, 36'hA, 7'h1, 1), 1, 0);
    cyc(IDL, 1, 0);
    cyc(mk(2'd1, 36'hB, 7'h2, 0), 1, 0);
    cyc(mk(2'd3, 36'hC, 7'h3, 0), 1, 0);
    cyc(mk(2'd2, 36'hD, 7'h4, 1), 1, 0);
    cyc(IDL, 1, 0);
    check_eq("gated_drop", drop_cnt, 0);

    // Over-length transaction
    for (int i = 0; i < 20; i++) cyc(mk(2'd1, 36'(100 + i), 7'(i), 1), 1, 0);
    cyc(mk(2'd2, 36'h999, 7'h7F, 1), 1, 0);
    cyc(IDL, 1, 0);
    check_eq("ovl_drop", drop_cnt, 5);
    check_eq("ovl_trunc", trunc, 1);
    cyc(mk(2'd1, 36'h55, 7'h5, 1), 1, 0);
    cyc(mk(2'd2, 36'h56, 7'h6, 1), 1, 0);
    cyc(IDL, 1, 0);

    // Overflow with a stalled consumer
    cyc(IDL, 1, 1);
    for (int i = 0; i < 10; i++) cyc(mk(2'd1, 36'(200 + i), 7'(i), 1), 0, 0);
    check_eq("ovf_cnt", fifo_cnt, 8);
    check_eq("ovf_drop", drop_cnt, 2);
    cyc(mk(2'd2, 36'h77, 7'h7, 1), 0, 0);
    check_eq("ovf_done_drop", drop_cnt, 3);
    for (int i = 0; i < 9; i++) cyc(IDL, 1, 0);
    cyc(mk(2'd2, 36'h78, 7'h8, 1), 1, 0);
    check_eq("ovf_recover", out_valid, 1);
    cyc(IDL, 1, 0);

    // Illegal cycle type and status clear
    cyc(mk(2'd3, 36'hEE, 7'h1, 1), 1, 0);
    check_eq("ill_set", illegal, 1);
    check_eq("ill_nopush", fifo_cnt, 0);
    cyc(IDL, 1, 1);
    check_eq("clr_ill", illegal, 0);
    check_eq("clr_trunc", trunc, 0);
    check_eq("clr_drop", drop_cnt, 0);

    // Asynchronous reset mid-transaction
    cyc(mk(2'd1, 36'h31, 7'h1, 1), 0, 0);
    cyc(mk(2'd1, 36'h32, 7'h2, 1), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(mk(2'd2, 36'h33, 7'h3, 1), 0, 0);
    check_eq("rst_done_valid", out_valid, 1);
    check_eq("rst_done_last", out_beat.last, 1);
    cyc(IDL, 1, 0);
    cyc(IDL, 1, 0);

    // Random traffic; alternating phases favour long or short transactions
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 300; i++) begin
        int r;
        logic [1:0] ct;
        r = $urandom_range(0, 31);
        if (r < 4) ct = 2'd0;
        else if (r < ((p % 2 == 0) ? 30 : 24)) ct = 2'd1;
        else if (r < 31) ct = 2'd2;
        else ct = 2'd3;
        cyc(mk(ct, {$urandom, 4'($urandom)}, 7'($urandom), ($urandom_range(0, 7) != 0)),
            (p < 4) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 99) == 0));
      end
    end
    for (int i = 0; i < 12; i++) cyc(IDL, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
